// File: rtl/periph_arbiter_pkg.sv
// periph_arbiter_pkg: lock-state encodings and master index constants
package periph_arbiter_pkg;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
endpackage

// File: rtl/periph_arbiter_if.sv
// periph_arbiter_if: two master request ports plus the shared peripheral register port
interface periph_arbiter_if;
  logic m0_req, m0_we, m0_lock, m0_gnt, m0_ack;
  logic m1_req, m1_we, m1_lock, m1_gnt, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  modport slave (
    input m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input s_rdata,
    output m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
    output s_we, s_addr, s_wdata
  );
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output s_rdata,
    input m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
    input s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/periph_arbiter_arb_rr2.sv
// arb_rr2: combinational 2-way round-robin picker; on a tie the master other than last wins
module arb_rr2
  import periph_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb gnt = &req ? (last == M1 ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/periph_arbiter.sv
// periph_arbiter: round-robin arbiter with bounded bus lock sharing one peripheral register port
module periph_arbiter
  import periph_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input logic clk,
  input logic rst,
  periph_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  lock_state_e state, state_nxt;
  logic owner, owner_nxt, last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0] req, rr_gnt, gnt;
  logic hold, any, winner, win_lock, win_we;
  logic ack0, ack1;
  logic [31:0] rd0, rd1;

  assign req = rst ? {bus.m1_req, bus.m0_req} : 2'b00;

  arb_rr2 u_rr (.req, .last, .gnt(rr_gnt));

  // an owner that stops requesting loses the lock in the same cycle
  always_comb begin
    hold = state == LOCKED && req[owner];
    gnt = hold ? (owner == M1 ? 2'b10 : 2'b01) : rr_gnt;
    any = |gnt;
    winner = gnt[1];
    win_lock = winner ? bus.m1_lock : bus.m0_lock;
    win_we = winner ? bus.m1_we : bus.m0_we;
    cnt_inc = cnt + CW'(1);
    state_nxt = UNLOCKED;
    owner_nxt = owner;
    last_nxt = any ? winner : last;
    cnt_nxt = '0;
    if (hold && win_lock && cnt_inc < CW'(MAX_LOCK)) begin
      state_nxt = LOCKED;
      cnt_nxt = cnt_inc;
    end else if (!hold && any && win_lock && MAX_LOCK > 1) begin
      state_nxt = LOCKED;
      owner_nxt = winner;
      cnt_nxt = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= UNLOCKED;
      owner <= M0;
      last <= M1;
      cnt <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last <= last_nxt;
      cnt <= cnt_nxt;
      ack0 <= gnt[0];
      ack1 <= gnt[1];
      rd0 <= gnt[0] && !bus.m0_we ? bus.s_rdata : '0;
      rd1 <= gnt[1] && !bus.m1_we ? bus.s_rdata : '0;
    end
  end

  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];
  assign bus.s_we = any & win_we;
  assign bus.s_addr = !any ? '0 : winner ? bus.m1_addr : bus.m0_addr;
  assign bus.s_wdata = !any ? '0 : winner ? bus.m1_wdata : bus.m0_wdata;
  assign bus.m0_ack = ack0 & rst;
  assign bus.m1_ack = ack1 & rst;
  assign bus.m0_rdata = rst ? rd0 : '0;
  assign bus.m1_rdata = rst ? rd1 : '0;
endmodule

// File: doc/periph_arbiter.md
# periph_arbiter

Two-master round-robin arbiter that shares the single peripheral register port (we/addr/wdata in, combinational rdata out) used by the GPIO block and its sibling peripherals. It sits between the core's load/store path (master 0) and a second requester such as a debug or DMA port (master 1). It accepts one single-beat transaction per cycle and returns a registered acknowledge/read-data one cycle later. It supports a bounded bus lock so one master can perform an atomic read-modify-write of a GPIO register.

## Interface
- MAX_LOCK, 4: maximum consecutive grants to one master under lock; must be ≥1, and 1 disables locking in effect.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- m0_req, m1_req  in  1  transaction request; held until the matching gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_lock, m1_lock  in  1  request to keep ownership after this transaction.
- m0_addr, m1_addr  in  32  register address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_gnt, m1_gnt  out  1  combinational; transaction is accepted this cycle.
- m0_ack, m1_ack  out  1  registered; pulses the cycle after a grant.
- m0_rdata, m1_rdata  out  32  registered; read data when ack, else 0.
- s_we  out  1  slave write enable.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data, combinational from s_addr.

## Operation
- State: lock_state (UNLOCKED / LOCKED), owner (1 bit), last (1 bit, last granted master), lock_cnt (clog2(MAX_LOCK+1) bits).
- UNLOCKED arbitration:
  - Only one master requests: that master wins.
  - Both request: the master != last wins.
  - No request: no grant.
- LOCKED arbitration:
  - Owner requests: owner wins regardless of the other master.
  - Owner does not request: lock is released in that same cycle, and the cycle is arbitrated as UNLOCKED.
- On every grant, last <= winner.
- Lock entry: a grant in UNLOCKED with winner lock=1 and MAX_LOCK>1 → LOCKED, owner <= winner, lock_cnt <= 1.
- Lock continuation: on an owner grant in LOCKED, let n = lock_cnt+1.
  - lock=1 and n < MAX_LOCK: stay LOCKED, lock_cnt <= n.
  - Otherwise: go to UNLOCKED, lock_cnt <= 0.
- Consecutive locked grants never exceed MAX_LOCK. After a forced release, last = owner, so the other master wins the next tie.
- Slave drive:
  - Grant: s_we = winner we; s_addr and s_wdata = winner's values.
  - No grant: s_we, s_addr and s_wdata are all 0.
  - A write takes effect in the slave at the same clock edge that ends the grant cycle.
- Response: at the edge ending a grant cycle, register mX_ack <= 1 for the winner only and 0 for the loser.
  - Read: mX_rdata <= s_rdata.
  - Write: mX_rdata <= 0.
  - Both outputs return to 0 the following cycle unless there is a new grant.
- Width rules: addr and data pass through unmodified; no address decode.

## Timing
- Grant latency: 0 cycles (gnt is combinational, in the same cycle as req).
- Ack/rdata latency: 1 cycle after the grant.
- Throughput: one transaction per cycle. Back-to-back grants to the same master give a contiguous ack train.
- Handshake: a master holds req/we/lock/addr/wdata stable until it sees gnt high. It may deassert req or change fields in the cycle after gnt.
- Reset values (while rst=0 and one cycle after): UNLOCKED, last=1 (so master 0 wins the first tie), lock_cnt=0.
  - All ack and rdata outputs are 0.
  - gnt and s_* outputs are forced to 0 during reset.
- Reset mid-lock or mid-transaction: the lock is dropped and any pending ack is discarded.
- Simultaneous events:
  - The owner's final locked grant and the other master's request in the same cycle: the owner wins that cycle and the other master wins the next.
  - The owner drops req while the other master requests: the other master is granted in that same cycle.

## Structure
- The shared defines header holds the lock-state encodings (UNLOCKED=1'b0, LOCKED=1'b1) and the master index constants (M0=1'b0, M1=1'b1).
- One sub-module: arb_rr2, a combinational 2-way round-robin picker (inputs req[1:0], last; outputs gnt[1:0]).
- The lock FSM, counter, slave mux and response registers live in the top level.

## Test plan
- Reset, then m0 writes addr 0x4 data 0xA5 alone:
  - Same cycle: m0_gnt=1, s_we=1, s_addr=0x4, s_wdata=0xA5.
  - Next cycle: m0_ack=1, m0_rdata=0.
- Both masters read continuously (slave returns addr as data, m0 addr 0x0, m1 addr 0x4):
  - Grants go m0, m1, m0, m1….
  - Acks lag one cycle, with m0_rdata=0x0 and m1_rdata=0x4.
- MAX_LOCK=4, m0 requests with lock=1, m1 requests continuously:
  - m0 is granted 4 consecutive cycles.
  - m1 is granted in cycle 5.
- m0 locks, then deasserts lock on its 2nd transaction:
  - m0 is granted in cycles 1–2.
  - m1 is granted in cycle 3.
- Reset pulse during LOCKED with a pending ack:
  - The ack is not delivered and all outputs are 0.
  - After release, a tie is granted to m0.
- No requests for 10 cycles:
  - s_we, s_addr and s_wdata stay 0.
  - No gnt or ack is asserted.
